pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Controls the reset of the fabric PLL that turns 125 MHz refclk into the SoC clock, and supervises its lock indication.
- Pulses the PLL reset, waits for a stable lock, then releases the system reset.
- Detects loss of lock and re-sequences, giving up after a bounded number of retries.
- Runs on refclk because the PLL output is not valid until lock. sys_rst_n is re-synchronised into outclk domains by consumers.

Parameters:
RST_PULSE_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock-high cycles required before release (>=1)
LOCK_TIMEOUT_CYCLES, 125000, max cycles in WAIT_LOCK+STABLE per attempt (1 ms @125 MHz)
MAX_RETRIES, 3, timeouts tolerated before FAULT (>=0)
SYNC_STAGES, 2, flops in the pll_locked synchroniser (>=2)

Ports:
refclk  in  1  reference clock, sole clock of the block
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL locked, asynchronous to refclk
soft_req  in  1  single-cycle request to re-sequence the PLL
pll_rst  out  1  active-high PLL reset
sys_rst_n  out  1  active-low system reset, refclk domain, registered
ready  out  1  high only in RUN
fault  out  1  high only in FAULT
lock_lost  out  1  sticky: lock dropped while in RUN; cleared by soft_req
retry_cnt  out  $clog2(MAX_RETRIES+1) (min 1)  timeouts in the current sequence
lock_loss_cnt  out  8  lock-loss event count (see Optional Feature)

Behaviour:
- Async reset values: pll_rst=1, sys_rst_n=0, ready=0, fault=0, lock_lost=0, retry_cnt=0, lock_loss_cnt=0. State=ASSERT_RST, all counters 0, synchroniser cleared.
- locked_s = pll_locked after SYNC_STAGES flops. All decisions use locked_s only.
- All outputs are registered and decoded from the state.
- ASSERT_RST: pll_rst=1, sys_rst_n=0. Count RST_PULSE_CYCLES cycles, then go to WAIT_LOCK. Clear the timeout timer on exit.
- WAIT_LOCK: pll_rst=0. Timeout timer increments each cycle.
  - locked_s=1 -> STABLE; clear the stable counter.
  - Timer reaches LOCK_TIMEOUT_CYCLES-1 -> if retry_cnt==MAX_RETRIES go to FAULT, else increment retry_cnt and go to ASSERT_RST.
- STABLE: timeout timer keeps running and is not reset.
  - Stable counter increments while locked_s=1.
  - locked_s=0 -> WAIT_LOCK.
  - Counter reaches LOCK_STABLE_CYCLES-1 with locked_s=1 -> RUN.
  - Timeout is handled as in WAIT_LOCK. If timeout and stable completion occur in the same cycle, the timeout wins.
- RUN: sys_rst_n=1, ready=1, retry_cnt cleared to 0.
  - locked_s=0 -> set lock_lost, increment lock_loss_cnt, go to ASSERT_RST. sys_rst_n goes low on the next edge.
- FAULT: pll_rst=1, sys_rst_n=0, fault=1. Leaves only on soft_req.
- soft_req:
  - In any state: go to ASSERT_RST, clear retry_cnt and lock_lost.
  - In ASSERT_RST: restart the pulse count.
  - Takes priority over every other transition in the same cycle.
- Release latency: ready rises exactly SYNC_STAGES+LOCK_STABLE_CYCLES+1 cycles after the first refclk edge that samples pll_locked high, provided lock stays high.
- Glitch handling: a lock glitch shorter than one cycle may be missed. Any sampled low during STABLE restarts qualification.
- Counters are sized with $clog2 of their limits and never wrap. Each is cleared on entering the state that uses it.
- rst_n assertion mid-sequence forces the reset values immediately (asynchronously).

Optional Feature:
- Macro: PLL_SEQ_LOCK_LOSS_COUNTER_EN.
- Defined: lock_loss_cnt is an 8-bit saturating counter (holds at 255). It increments once per RUN->ASSERT_RST transition caused by lock loss, is cleared only by rst_n, and is not affected by soft_req.
- Undefined: no counter logic; lock_loss_cnt tied to 8'd0. lock_lost still functions.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=50, MAX_RETRIES=2, SYNC_STAGES=2.
- Nominal bring-up: release rst_n; pll_locked rises 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; ready and sys_rst_n rise 11 cycles after lock sampled high; retry_cnt=0.
- Lock glitch: lock high, dropped for 2 cycles after 5 qualified cycles, then high -> back through WAIT_LOCK; ready rises 11 cycles after the second rise; no retry.
- Timeout/retry/fault: pll_locked held 0 -> three 4-cycle pll_rst pulses separated by 50-cycle waits, retry_cnt 0->1->2; then fault=1, pll_rst=1 held; soft_req -> fault=0, retry_cnt=0, new pulse.
- Loss of lock in RUN: drop pll_locked -> sys_rst_n low and ready low 3 cycles later, lock_lost=1, lock_loss_cnt=1 (macro defined; 0 when undefined); relock -> ready again with lock_lost still 1 until soft_req.
- soft_req same cycle as STABLE completion -> ASSERT_RST taken; ready stays 0.
- Async reset during STABLE -> outputs return to reset values without a clock edge; sequence restarts cleanly.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Pulses the fabric PLL reset, qualifies the synchronised lock indication,
// releases the refclk-domain system reset and re-sequences on loss of lock.
// A bounded number of lock timeouts is tolerated before parking in FAULT.
// Optional build macro: PLL_SEQ_LOCK_LOSS_COUNTER_EN enables the saturating
// lock-loss event counter on lock_loss_cnt (tied to zero otherwise).
//
// state      | meaning
// -----------+---------------------------------------------------------
// ASSERT_RST | pll_rst held high for RST_PULSE_CYCLES
// WAIT_LOCK  | PLL released, waiting for synchronised lock
// STABLE     | lock seen, counting consecutive locked cycles
// RUN        | system reset released, supervising lock
// FAULT      | retries exhausted, PLL held in reset until soft_req
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2,
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               soft_req,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               fault,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [7:0]         lock_loss_cnt
);

  localparam int PULSE_W  = (RST_PULSE_CYCLES > 1)    ? $clog2(RST_PULSE_CYCLES)    : 1;
  localparam int STABLE_W = (LOCK_STABLE_CYCLES > 1)  ? $clog2(LOCK_STABLE_CYCLES)  : 1;
  localparam int TIMER_W  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;

  localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(RST_PULSE_CYCLES - 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_ASSERT_RST = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_STABLE     = 3'd2,
    S_RUN        = 3'd3,
    S_FAULT      = 3'd4
  } state_t;

  state_t               r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [PULSE_W-1:0]   r_pulse_cnt;
  logic [STABLE_W-1:0]  r_stable_cnt;
  logic [TIMER_W-1:0]   r_timer;
  logic [RETRY_W-1:0]   r_retry_cnt;
  logic                 r_lock_lost;
  logic                 r_pll_rst;
  logic                 r_sys_rst_n;
  logic                 r_ready;
  logic                 r_fault;

  logic w_locked_s;
  logic w_timeout;
  logic w_qualifying;

  assign w_locked_s   = r_sync[SYNC_STAGES-1];
  assign w_timeout    = (r_timer == TIMER_LAST);
  assign w_qualifying = (r_state == S_WAIT_LOCK) || (r_state == S_STABLE);

  // Bring the asynchronous PLL lock flag into the refclk domain.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Sequencer FSM; outputs are registered decodes of the current state, so
  // they follow a state change by one edge.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_ASSERT_RST;
      r_pulse_cnt  <= '0;
      r_stable_cnt <= '0;
      r_timer      <= '0;
      r_retry_cnt  <= '0;
      r_lock_lost  <= 1'b0;
      r_pll_rst    <= 1'b1;
      r_sys_rst_n  <= 1'b0;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_pll_rst   <= (r_state == S_ASSERT_RST) || (r_state == S_FAULT);
      r_sys_rst_n <= (r_state == S_RUN);
      r_ready     <= (r_state == S_RUN);
      r_fault     <= (r_state == S_FAULT);

      if (soft_req) begin
        r_state     <= S_ASSERT_RST;
        r_pulse_cnt <= '0;
        r_retry_cnt <= '0;
        r_lock_lost <= 1'b0;
      end else if (w_qualifying && w_timeout) begin
        // The timeout budget spans WAIT_LOCK and STABLE and beats completion.
        if (r_retry_cnt == RETRY_MAX) begin
          r_state <= S_FAULT;
        end else begin
          r_retry_cnt <= r_retry_cnt + 1'b1;
          r_pulse_cnt <= '0;
          r_state     <= S_ASSERT_RST;
        end
      end else begin
        case (r_state)
          S_ASSERT_RST: begin
            if (r_pulse_cnt == PULSE_LAST) begin
              r_timer <= '0;
              r_state <= S_WAIT_LOCK;
            end else begin
              r_pulse_cnt <= r_pulse_cnt + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            r_timer <= r_timer + 1'b1;
            if (w_locked_s) begin
              r_stable_cnt <= '0;
              r_state      <= S_STABLE;
            end
          end
          S_STABLE: begin
            r_timer <= r_timer + 1'b1;
            if (!w_locked_s) begin
              r_state <= S_WAIT_LOCK;
            end else if (r_stable_cnt == STABLE_LAST) begin
              r_state <= S_RUN;
            end else begin
              r_stable_cnt <= r_stable_cnt + 1'b1;
            end
          end
          S_RUN: begin
            r_retry_cnt <= '0;
            if (!w_locked_s) begin
              r_lock_lost <= 1'b1;
              r_pulse_cnt <= '0;
              r_state     <= S_ASSERT_RST;
            end
          end
          S_FAULT: begin
            r_state <= S_FAULT;
          end
          default: begin
            r_pulse_cnt <= '0;
            r_state     <= S_ASSERT_RST;
          end
        endcase
      end
    end
  end

`ifdef PLL_SEQ_LOCK_LOSS_COUNTER_EN
  logic [7:0] r_lock_loss_cnt;
  logic       w_lock_loss_evt;

  // Same condition as the RUN -> ASSERT_RST lock-loss transition above.
  assign w_lock_loss_evt = (r_state == S_RUN) && !w_locked_s && !soft_req;

  // Saturating lock-loss event counter; only rst_n clears it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_loss_cnt <= 8'd0;
    end else if (w_lock_loss_evt && (r_lock_loss_cnt != 8'hFF)) begin
      r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_lock_loss_cnt;
`else
  assign lock_loss_cnt = 8'd0;
`endif

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign ready     = r_ready;
  assign fault     = r_fault;
  assign lock_lost = r_lock_lost;
  assign retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer with short sequencing parameters.
module tb_pll_reset_sequencer;
  localparam int RST_PULSE = 4;
  localparam int STABLE    = 8;
  localparam int TIMEOUT   = 50;
  localparam int MAXR      = 2;
  localparam int SYNC      = 2;
  localparam int REL_LAT   = SYNC + STABLE + 1;
`ifdef PLL_SEQ_LOCK_LOSS_COUNTER_EN
  localparam int LLC_STEP = 1;
`else
  localparam int LLC_STEP = 0;
`endif

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_req = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fault, lock_lost;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int exp_llc = 0;
  int exp_q[$];

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(RST_PULSE), .LOCK_STABLE_CYCLES(STABLE),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRIES(MAXR), .SYNC_STAGES(SYNC)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_req(soft_req),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault),
    .lock_lost(lock_lost), .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  // Drive pll_locked just after a rising edge; c is that edge's index.
  task automatic drive_lock(input logic v, output int c);
    @(posedge refclk); #1 pll_locked = v; c = cyc;
  endtask

  task automatic pulse_soft();
    @(posedge refclk); #1 soft_req = 1'b1;
    @(posedge refclk); #1 soft_req = 1'b0;
  endtask

  // Edge index of the first negedge sample with ready high (-1 if none).
  task automatic wait_ready(output int obs);
    obs = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge refclk);
      if (ready === 1'b1) begin obs = cyc; return; end
    end
  endtask

  // Count consecutive negedge samples (starting now) with pll_rst == lvl.
  task automatic count_pll_rst(input logic lvl, output int n);
    n = 0;
    while (pll_rst === lvl && n < 400) begin n++; @(negedge refclk); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b0; soft_req = 1'b0;
    repeat (3) @(negedge refclk);
    n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    n_tests++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_sys_rst_n: got %b want 0", sys_rst_n); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_tests++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL reset_lock_lost: got %b want 0", lock_lost); end
    n_tests++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_retry_cnt: got %0d want 0", retry_cnt); end
    n_tests++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_lock_loss_cnt: got %0d want 0", lock_loss_cnt); end
  endtask

  task automatic test_nominal();
    int n, c, obs, e;
    rst_n = 1'b1;
    exp_q.push_back(RST_PULSE);
    @(negedge refclk);
    count_pll_rst(1'b1, n);
    e = exp_q.pop_front();
    n_tests++; if (n !== e) begin n_fail++; $display("FAIL nominal_pulse_len: got %0d want %0d", n, e); end
    repeat (9) @(posedge refclk);
    drive_lock(1'b1, c);
    exp_q.push_back(c + 1 + REL_LAT);
    wait_ready(obs);
    e = exp_q.pop_front();
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL nominal_ready_cycle: got %0d want %0d", obs, e); end
    n_tests++; if (sys_rst_n !== 1'b1) begin n_fail++; $display("FAIL nominal_sys_rst_n: got %b want 1", sys_rst_n); end
    n_tests++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL nominal_retry_cnt: got %0d want 0", retry_cnt); end
  endtask

  task automatic test_glitch();
    int n, c, obs, e;
    @(posedge refclk); #1 pll_locked = 1'b0; soft_req = 1'b1;
    @(posedge refclk); #1 soft_req = 1'b0;
    @(negedge refclk);
    count_pll_rst(1'b0, n);
    count_pll_rst(1'b1, n);
    drive_lock(1'b1, c);
    repeat (7) @(posedge refclk);
    #1 pll_locked = 1'b0;
    repeat (2) @(posedge refclk);
    #1 pll_locked = 1'b1; c = cyc;
    exp_q.push_back(c + 1 + REL_LAT);
    wait_ready(obs);
    e = exp_q.pop_front();
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL glitch_ready_cycle: got %0d want %0d", obs, e); end
    n_tests++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL glitch_retry_cnt: got %0d want 0", retry_cnt); end
  endtask

  task automatic test_timeout_fault();
    int n, c, obs, e;
    logic [1:0] r;
    @(posedge refclk); #1 pll_locked = 1'b0; soft_req = 1'b1;
    @(posedge refclk); #1 soft_req = 1'b0;
    for (int i = 0; i <= MAXR; i++) begin
      exp_q.push_back(RST_PULSE); exp_q.push_back(i); exp_q.push_back(TIMEOUT);
    end
    @(negedge refclk);
    count_pll_rst(1'b0, n);
    for (int i = 0; i <= MAXR; i++) begin
      r = retry_cnt;
      count_pll_rst(1'b1, n);
      e = exp_q.pop_front();
      n_tests++; if (n !== e) begin n_fail++; $display("FAIL timeout_pulse%0d_len: got %0d want %0d", i, n, e); end
      e = exp_q.pop_front();
      n_tests++; if (int'(r) !== e) begin n_fail++; $display("FAIL timeout_retry%0d: got %0d want %0d", i, r, e); end
      count_pll_rst(1'b0, n);
      e = exp_q.pop_front();
      n_tests++; if (n !== e) begin n_fail++; $display("FAIL timeout_wait%0d_len: got %0d want %0d", i, n, e); end
    end
    n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_rise: got %b want 1", fault); end
    repeat (5) @(negedge refclk);
    n_tests++; if (pll_rst !== 1'b1 || fault !== 1'b1) begin n_fail++; $display("FAIL fault_hold: got pll_rst=%b fault=%b want 1/1", pll_rst, fault); end
    n_tests++; if (retry_cnt !== 2'd2) begin n_fail++; $display("FAIL fault_retry_cnt: got %0d want 2", retry_cnt); end
    pulse_soft();
    @(negedge refclk);
    @(negedge refclk);
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got %b want 0", fault); end
    n_tests++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL fault_retry_clear: got %0d want 0", retry_cnt); end
    count_pll_rst(1'b1, n);
    n_tests++; if (n !== RST_PULSE) begin n_fail++; $display("FAIL fault_new_pulse_len: got %0d want %0d", n, RST_PULSE); end
    drive_lock(1'b1, c);
    exp_q.push_back(c + 1 + REL_LAT);
    wait_ready(obs);
    e = exp_q.pop_front();
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL fault_recover_ready: got %0d want %0d", obs, e); end
  endtask

  task automatic test_lock_loss();
    int n, c, obs, e, f;
    drive_lock(1'b0, c);
    exp_q.push_back(c + 1 + 3);
    exp_llc = exp_llc + LLC_STEP;
    obs = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge refclk);
      if (sys_rst_n === 1'b0) begin obs = cyc; break; end
    end
    e = exp_q.pop_front();
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL loss_sys_rst_cycle: got %0d want %0d", obs, e); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL loss_ready: got %b want 0", ready); end
    n_tests++; if (lock_lost !== 1'b1) begin n_fail++; $display("FAIL loss_lock_lost: got %b want 1", lock_lost); end
    n_tests++; if (int'(lock_loss_cnt) !== exp_llc) begin n_fail++; $display("FAIL loss_cnt: got %0d want %0d", lock_loss_cnt, exp_llc); end
    count_pll_rst(1'b1, n);
    drive_lock(1'b1, c);
    exp_q.push_back(c + 1 + REL_LAT);
    wait_ready(obs);
    e = exp_q.pop_front();
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL loss_relock_ready: got %0d want %0d", obs, e); end
    n_tests++; if (lock_lost !== 1'b1) begin n_fail++; $display("FAIL loss_sticky: got %b want 1", lock_lost); end
    pulse_soft();
    @(negedge refclk);
    n_tests++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL loss_soft_clear: got %b want 0", lock_lost); end
    n_tests++; if (int'(lock_loss_cnt) !== exp_llc) begin n_fail++; $display("FAIL loss_cnt_after_soft: got %0d want %0d", lock_loss_cnt, exp_llc); end
    count_pll_rst(1'b0, n);
    count_pll_rst(1'b1, n);
    f = cyc;
    exp_q.push_back(f + STABLE + 1);
    wait_ready(obs);
    e = exp_q.pop_front();
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL held_lock_ready: got %0d want %0d", obs, e); end
  endtask

  task automatic test_soft_collision();
    int n, obs, e, f, hi;
    pulse_soft();
    @(negedge refclk);
    count_pll_rst(1'b0, n);
    count_pll_rst(1'b1, n);
    f = cyc;
    repeat (7) @(posedge refclk);
    #1 soft_req = 1'b1;
    @(posedge refclk); #1 soft_req = 1'b0;
    @(negedge refclk);
    @(negedge refclk);
    n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL collide_pll_rst: got %b want 1", pll_rst); end
    hi = (ready === 1'b1) ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge refclk);
      if (ready === 1'b1) hi++;
    end
    n_tests++; if (hi !== 0) begin n_fail++; $display("FAIL collide_ready_stays_low: got %0d high samples want 0", hi); end
    exp_q.push_back(f + STABLE + RST_PULSE + 1 + STABLE + 1);
    wait_ready(obs);
    e = exp_q.pop_front();
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL collide_resequence_ready: got %0d want %0d", obs, e); end
  endtask

  task automatic test_async_reset();
    int n, c, obs, e, f;
    drive_lock(1'b0, c);
    for (int i = 0; i < 20; i++) begin
      @(negedge refclk);
      if (sys_rst_n === 1'b0) break;
    end
    count_pll_rst(1'b1, n);
    drive_lock(1'b1, c);
    repeat (4) @(posedge refclk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL async_pll_rst: got %b want 1", pll_rst); end
    n_tests++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL async_lock_lost: got %b want 0", lock_lost); end
    n_tests++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL async_lock_loss_cnt: got %0d want 0", lock_loss_cnt); end
    n_tests++; if (sys_rst_n !== 1'b0 || ready !== 1'b0 || fault !== 1'b0 || retry_cnt !== 2'd0) begin
      n_fail++; $display("FAIL async_others: got sys_rst_n=%b ready=%b fault=%b retry=%0d want 0/0/0/0", sys_rst_n, ready, fault, retry_cnt);
    end
    exp_llc = 0;
    @(negedge refclk);
    rst_n = 1'b1;
    @(negedge refclk);
    count_pll_rst(1'b1, n);
    n_tests++; if (n !== RST_PULSE) begin n_fail++; $display("FAIL async_restart_pulse: got %0d want %0d", n, RST_PULSE); end
    f = cyc;
    exp_q.push_back(f + STABLE + 1);
    wait_ready(obs);
    e = exp_q.pop_front();
    n_tests++; if (obs !== e) begin n_fail++; $display("FAIL async_restart_ready: got %0d want %0d", obs, e); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_timeout_fault();
    test_lock_loss();
    test_soft_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
